// File: rtl/apb_fifo_pkg.sv
// Shared definitions for the APB mailbox FIFO peripheral:
// register offsets, FSM states and status register bit positions.
package apb_fifo_pkg;

    localparam logic [3:0] CR_OFS     = 4'h0;
    localparam logic [3:0] SR_OFS     = 4'h4;
    localparam logic [3:0] DATA_OFS   = 4'h8;
    localparam logic [3:0] THRESH_OFS = 4'hC;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    localparam int SR_EMPTY_BIT = 0;
    localparam int SR_FULL_BIT  = 1;
    localparam int SR_OVF_BIT   = 2;
    localparam int SR_UNF_BIT   = 3;
    localparam int SR_CNT_LSB   = 8;
    localparam int SR_CNT_W     = 5;

endpackage

// File: rtl/apb_fifo_periph_fifo_core.sv
// Synchronous FIFO with push/pop strobes; the head entry is always visible on rdata.
// Pushes when full and pops when empty are ignored here; the caller tracks the error flags.
module fifo_core #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers are log2(DEPTH) wide so they wrap at DEPTH without explicit compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/apb_fifo_periph.sv
// APB responder exposing a 32-bit mailbox FIFO with control, status and threshold registers.
// Every access completes after WAIT_STATES cycles of PREADY low.
module apb_fifo_periph
    import apb_fifo_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [3:0]  PADDR,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic [31:0] PWDATA,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        irq
);

    localparam int          CW        = $clog2(DEPTH) + 1;
    localparam logic [2:0]  WAIT_LOAD = 3'(WAIT_STATES - 1);

    state_t         state;
    logic [2:0]     wait_cnt;
    logic           irq_en;
    logic [4:0]     thresh;
    logic           ovf;
    logic           unf;

    logic [31:0]    fifo_rdata;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic [4:0]     count_ext;
    logic [4:0]     thresh_eff;

    logic           access;
    logic           complete;
    logic           data_hit;
    logic           do_push;
    logic           do_pop;
    logic [31:0]    sr_val;
    logic [31:0]    rd_value;
    logic [31:0]    read_val;

    assign access    = PSEL && PENABLE;
    assign complete  = (state == WAIT) && PREADY && access;
    assign data_hit  = (PADDR == DATA_OFS);
    assign do_push   = complete && PWRITE && data_hit;
    assign do_pop    = complete && !PWRITE && data_hit;
    assign count_ext = 5'(fifo_count);
    assign thresh_eff = (thresh == 5'd0) ? 5'd1 : thresh;

    fifo_core #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (do_push),
        .pop   (do_pop),
        .wdata (PWDATA),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        sr_val                             = '0;
        sr_val[SR_EMPTY_BIT]               = fifo_empty;
        sr_val[SR_FULL_BIT]                = fifo_full;
        sr_val[SR_OVF_BIT]                 = ovf;
        sr_val[SR_UNF_BIT]                 = unf;
        sr_val[SR_CNT_LSB +: SR_CNT_W]     = count_ext;

        rd_value = '0;
        case (PADDR)
            CR_OFS:     rd_value = {31'b0, irq_en};
            SR_OFS:     rd_value = sr_val;
            DATA_OFS:   rd_value = fifo_empty ? 32'h0 : fifo_rdata;
            THRESH_OFS: rd_value = {27'b0, thresh};
            default:    rd_value = '0;
        endcase

        read_val = PWRITE ? 32'h0 : rd_value;
    end

    // PRDATA is captured on the same edge that raises PREADY, so it is valid
    // exactly in the completing cycle; the FIFO head cannot move mid-transfer.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state    <= IDLE;
            wait_cnt <= '0;
            PREADY   <= 1'b0;
            PRDATA   <= '0;
        end else begin
            PREADY <= 1'b0;
            PRDATA <= '0;
            case (state)
                IDLE: begin
                    if (access) begin
                        state    <= WAIT;
                        wait_cnt <= WAIT_LOAD;
                        if (WAIT_LOAD == 3'd0) begin
                            PREADY <= 1'b1;
                            PRDATA <= read_val;
                        end
                    end
                end
                WAIT: begin
                    if (!access || PREADY) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                        if (wait_cnt == 3'd1) begin
                            PREADY <= 1'b1;
                            PRDATA <= read_val;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            irq_en <= 1'b0;
            thresh <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            if (complete && PWRITE) begin
                case (PADDR)
                    CR_OFS:     irq_en <= PWDATA[0];
                    THRESH_OFS: thresh <= PWDATA[4:0];
                    SR_OFS: begin
                        if (PWDATA[SR_OVF_BIT]) ovf <= 1'b0;
                        if (PWDATA[SR_UNF_BIT]) unf <= 1'b0;
                    end
                    default: ;
                endcase
            end
            if (do_push && fifo_full) begin
                ovf <= 1'b1;
            end
            if (do_pop && fifo_empty) begin
                unf <= 1'b1;
            end
        end
    end

    // A zero threshold acts as one, which the count != 0 term already guarantees.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_en && (count_ext >= thresh_eff) && (count_ext != 5'd0);
        end
    end

endmodule

// File: tb/tb_apb_fifo_periph.sv
// Directed self-checking bench for apb_fifo_periph with DEPTH=8, WAIT_STATES=1.
module tb_apb_fifo_periph;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [3:0]  PADDR;
    logic        PWRITE;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic        PSEL;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        irq;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] rd;
    int          cyc;

    always #5 PCLK = ~PCLK;

    apb_fifo_periph #(
        .DEPTH       (8),
        .WAIT_STATES (1)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PADDR   (PADDR),
        .PWRITE  (PWRITE),
        .PENABLE (PENABLE),
        .PWDATA  (PWDATA),
        .PSEL    (PSEL),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .irq     (irq)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    // One complete APB transfer; called #1 after a rising edge, returns #1 after the edge that completes it.
    task automatic applyStimulus(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output int cycles);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = wdata;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        cycles  = 1;
        while (PREADY !== 1'b1 && cycles < 20) begin
            @(posedge PCLK); #1;
            cycles++;
        end
        if (PREADY !== 1'b1) checkOutput("pready_timeout", {31'b0, PREADY}, 32'h1);
        rdata = PRDATA;
        @(posedge PCLK); #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
    endtask

    task automatic apbWrite(input logic [3:0] addr, input logic [31:0] data);
        logic [31:0] d;
        int c;
        applyStimulus(1'b1, addr, data, d, c);
    endtask

    task automatic readCheck(input string tag, input logic [3:0] addr, input logic [31:0] expected);
        logic [31:0] d;
        int c;
        applyStimulus(1'b0, addr, 32'h0, d, c);
        checkOutput(tag, d, expected);
    endtask

    task automatic tick();
        @(posedge PCLK); #1;
    endtask

    initial begin
        PRESET  = 1'b1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = 4'h0;
        PWDATA  = 32'h0;
        repeat (3) @(posedge PCLK);
        #1;
        checkOutput("reset_pready", {31'b0, PREADY}, 32'h0);
        checkOutput("reset_prdata", PRDATA, 32'h0);
        checkOutput("reset_irq", {31'b0, irq}, 32'h0);
        PRESET = 1'b0;
        tick();

        // Reset state and latency
        applyStimulus(1'b0, 4'h4, 32'h0, rd, cyc);
        checkOutput("sr_after_reset", rd, 32'h0000_0001);
        checkOutput("ready_latency", cyc, 32'd2);
        checkOutput("pready_drop", {31'b0, PREADY}, 32'h0);
        checkOutput("prdata_idle", PRDATA, 32'h0);
        readCheck("cr_reset", 4'h0, 32'h0);
        readCheck("thresh_reset", 4'hC, 32'h0);

        // Ordered push/pop
        apbWrite(4'h8, 32'hA5A5_0001);
        apbWrite(4'h8, 32'hA5A5_0002);
        apbWrite(4'h8, 32'hA5A5_0003);
        readCheck("sr_count3", 4'h4, 32'h0000_0300);
        readCheck("pop1", 4'h8, 32'hA5A5_0001);
        readCheck("sr_count2", 4'h4, 32'h0000_0200);
        readCheck("pop2", 4'h8, 32'hA5A5_0002);
        readCheck("pop3", 4'h8, 32'hA5A5_0003);
        readCheck("sr_drained", 4'h4, 32'h0000_0001);

        // Overflow
        for (int i = 1; i <= 8; i++) apbWrite(4'h8, 32'hC0DE_0000 + i);
        readCheck("sr_full", 4'h4, 32'h0000_0802);
        apbWrite(4'h8, 32'hC0DE_0009);
        readCheck("sr_overflow", 4'h4, 32'h0000_0806);
        apbWrite(4'h4, 32'h0000_0004);
        readCheck("sr_ovf_clear", 4'h4, 32'h0000_0802);
        for (int i = 1; i <= 8; i++) readCheck($sformatf("pop_full_%0d", i), 4'h8, 32'hC0DE_0000 + i);
        readCheck("sr_after_full", 4'h4, 32'h0000_0001);

        // Underflow
        readCheck("pop_empty", 4'h8, 32'h0);
        readCheck("sr_underflow", 4'h4, 32'h0000_0009);
        apbWrite(4'h8, 32'h0000_1234);
        readCheck("sr_unf_push", 4'h4, 32'h0000_0108);
        readCheck("pop_after_unf", 4'h8, 32'h0000_1234);
        apbWrite(4'h4, 32'h0000_0008);
        readCheck("sr_unf_clear", 4'h4, 32'h0000_0001);

        // Unmapped offsets
        apbWrite(4'h1, 32'hFFFF_FFFF);
        readCheck("unmapped_read", 4'h1, 32'h0);
        readCheck("cr_untouched", 4'h0, 32'h0);

        // Threshold interrupt
        apbWrite(4'h0, 32'h1);
        apbWrite(4'hC, 32'h3);
        readCheck("cr_readback", 4'h0, 32'h1);
        readCheck("thresh_readback", 4'hC, 32'h3);
        apbWrite(4'h8, 32'h0000_0011);
        apbWrite(4'h8, 32'h0000_0022);
        tick();
        checkOutput("irq_count2", {31'b0, irq}, 32'h0);
        apbWrite(4'h8, 32'h0000_0033);
        checkOutput("irq_not_yet", {31'b0, irq}, 32'h0);
        tick();
        checkOutput("irq_count3", {31'b0, irq}, 32'h1);
        readCheck("irq_pop", 4'h8, 32'h0000_0011);
        tick();
        checkOutput("irq_after_pop", {31'b0, irq}, 32'h0);
        readCheck("drain_a", 4'h8, 32'h0000_0022);
        readCheck("drain_b", 4'h8, 32'h0000_0033);

        // THRESH=0 acts as 1
        apbWrite(4'hC, 32'h0);
        tick();
        checkOutput("irq_t0_empty", {31'b0, irq}, 32'h0);
        apbWrite(4'h8, 32'h0000_0044);
        tick();
        checkOutput("irq_t0_one", {31'b0, irq}, 32'h1);
        readCheck("pop_t0", 4'h8, 32'h0000_0044);
        tick();
        checkOutput("irq_t0_drained", {31'b0, irq}, 32'h0);
        apbWrite(4'h0, 32'h0);

        // Protocol violation: PSEL/PENABLE drop during WAIT
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'h8; PWDATA = 32'h0000_0BAD;
        tick();
        PENABLE = 1'b1;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        tick();
        checkOutput("abort_pready", {31'b0, PREADY}, 32'h0);
        readCheck("sr_after_abort", 4'h4, 32'h0000_0001);

        // Reset during WAIT of a DATA write
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'h8; PWDATA = 32'hDEAD_0001;
        tick();
        PENABLE = 1'b1;
        tick();
        PRESET = 1'b1;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PRESET = 1'b0;
        checkOutput("rst_mid_pready", {31'b0, PREADY}, 32'h0);
        checkOutput("rst_mid_prdata", PRDATA, 32'h0);
        tick();
        readCheck("sr_after_rst_mid", 4'h4, 32'h0000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
